// File: rtl/boot_mem_arbiter.sv
// Round-robin arbiter sharing the combinational boot ROM between the fetch and data buses.
// Optional read lock of the data port is enabled by defining BOOT_MEM_LOCK_EN.
module boot_mem_arbiter #(
   parameter int ADDR_WIDTH = 14,
   parameter int MEM_WORDS  = 380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_gnt,
   output logic        instr_rvalid,
   output logic [31:0] instr_rdata,
   output logic        instr_err,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        data_err,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        lock
);

   typedef enum logic {
      OWNER_INSTR,
      OWNER_DATA
   } owner_e;

   owner_e      last_owner;
   logic [31:0] mem_addr_q;
   logic        instr_resp_valid, instr_resp_err;
   logic        data_resp_valid, data_resp_err;
   logic [31:0] instr_resp_data, data_resp_data;
   logic        instr_bad, data_bad, data_lock_err;

   // Misaligned, beyond the populated words, or outside the boot window.
   function automatic logic addr_bad(input logic [31:0] addr);
      logic [ADDR_WIDTH-3:0] idx;
      idx = addr[ADDR_WIDTH-1:2];
      return (addr[1:0] != 2'b00) || (addr[31:ADDR_WIDTH] != '0) ||
             (32'(idx) >= 32'(MEM_WORDS));
   endfunction

   assign instr_bad = addr_bad(instr_addr);
   assign data_bad  = addr_bad(data_addr) || data_we || data_lock_err;

`ifdef BOOT_MEM_LOCK_EN
   logic locked;

   // Sticky: only reset reopens the data port. The registered value means a
   // read in the same cycle as the lock pulse still completes normally.
   always_ff @(posedge clk) begin
      if (rst)
         locked <= 1'b0;
      else if (lock)
         locked <= 1'b1;
   end

   assign data_lock_err = locked;
`else
   logic unused_lock;
   assign unused_lock   = lock;
   assign data_lock_err = 1'b0;
`endif

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      instr_gnt = 1'b0;
      data_gnt  = 1'b0;
      if (!rst) begin
         if (instr_req && (!data_req || last_owner == OWNER_DATA))
            instr_gnt = 1'b1;
         else if (data_req)
            data_gnt = 1'b1;
      end
   end

   // Hold the last address when idle to avoid toggling the ROM inputs.
   assign mem_addr = instr_gnt ? instr_addr :
                     data_gnt  ? data_addr  : mem_addr_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner       <= OWNER_DATA;
         mem_addr_q       <= 32'h0;
         instr_resp_valid <= 1'b0;
         instr_resp_err   <= 1'b0;
         instr_resp_data  <= 32'h0;
         data_resp_valid  <= 1'b0;
         data_resp_err    <= 1'b0;
         data_resp_data   <= 32'h0;
      end else begin
         mem_addr_q       <= mem_addr;
         if (instr_gnt)
            last_owner <= OWNER_INSTR;
         else if (data_gnt)
            last_owner <= OWNER_DATA;

         instr_resp_valid <= instr_gnt;
         instr_resp_err   <= instr_gnt && instr_bad;
         if (instr_gnt)
            instr_resp_data <= instr_bad ? 32'h0 : mem_rdata;

         data_resp_valid  <= data_gnt;
         data_resp_err    <= data_gnt && data_bad;
         if (data_gnt)
            data_resp_data <= data_bad ? 32'h0 : mem_rdata;
      end
   end

   // A response still pending while reset is high is never presented.
   assign instr_rvalid = instr_resp_valid && !rst;
   assign instr_err    = instr_resp_err && !rst;
   assign instr_rdata  = instr_resp_data;
   assign data_rvalid  = data_resp_valid && !rst;
   assign data_err     = data_resp_err && !rst;
   assign data_rdata   = data_resp_data;

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Directed bench for boot_mem_arbiter with a small ROM model on the memory port.
// Define BOOT_MEM_LOCK_EN for both bench and RTL to exercise the lock feature.
module tb_boot_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_addr, instr_rdata;
   logic        data_req, data_we, data_gnt, data_rvalid, data_err;
   logic [31:0] data_addr, data_rdata;
   logic [31:0] mem_addr, mem_rdata;
   logic        lock;

   int total  = 0;
   int passed = 0;

   boot_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
      .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_gnt(data_gnt),
      .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .lock(lock)
   );

   always #5 clk = ~clk;

   // ROM contents: word 67 is 0x93, other populated words are B007_0000 + index.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [11:0] i;
      i = a[13:2];
      if (i == 12'd67)  return 32'h0000_0093;
      if (i < 12'd380)  return {16'hB007, 4'h0, i};
      return 32'hDEAD_BEEF;
   endfunction

   assign mem_rdata = rom_word(mem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; lock = 1'b0;
      instr_req = 1'b0; instr_addr = 32'h0;
      data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0;
      tick; tick;
      rst = 1'b0; #1;
      chk("rst_instr_gnt", 32'(instr_gnt), 32'h0);
      chk("rst_data_gnt", 32'(data_gnt), 32'h0);
      chk("rst_instr_rvalid", 32'(instr_rvalid), 32'h0);
      chk("rst_data_rvalid", 32'(data_rvalid), 32'h0);
      chk("rst_errs", {30'h0, instr_err, data_err}, 32'h0);
      chk("rst_instr_rdata", instr_rdata, 32'h0);
      chk("rst_data_rdata", data_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);

      // Contention from reset: INSTR, DATA, INSTR, DATA.
      instr_req = 1'b1; instr_addr = 32'h0; data_req = 1'b1; data_addr = 32'h10C; #1;
      chk("cont1_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
      chk("cont1_mem_addr", mem_addr, 32'h0);
      tick;
      chk("cont2_instr_rvalid", 32'(instr_rvalid), 32'h1);
      chk("cont2_instr_rdata", instr_rdata, 32'hB007_0000);
      chk("cont2_data_rvalid", 32'(data_rvalid), 32'h0);
      #1;
      chk("cont2_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
      chk("cont2_mem_addr", mem_addr, 32'h10C);
      tick;
      chk("cont3_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h1);
      chk("cont3_data_rdata", data_rdata, 32'h0000_0093);
      chk("cont3_data_err", 32'(data_err), 32'h0);
      #1;
      chk("cont3_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
      tick;
      chk("cont4_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h2);
      #1;
      chk("cont4_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
      tick;
      instr_req = 1'b0; data_req = 1'b0;
      chk("cont5_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h1);
      chk("cont5_data_rdata", data_rdata, 32'h0000_0093);
      #1;
      chk("idle_gnt", {30'h0, instr_gnt, data_gnt}, 32'h0);
      chk("idle_mem_addr_hold", mem_addr, 32'h10C);
      tick;
      chk("idle_data_rvalid", 32'(data_rvalid), 32'h0);
      chk("idle_data_rdata_hold", data_rdata, 32'h0000_0093);

      // Single fetch at 0x0.
      instr_req = 1'b1; instr_addr = 32'h0; #1;
      chk("fetch_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
      tick;
      instr_req = 1'b0;
      chk("fetch_rvalid", 32'(instr_rvalid), 32'h1);
      chk("fetch_rdata", instr_rdata, 32'hB007_0000);
      chk("fetch_err", 32'(instr_err), 32'h0);

      // Error cases.
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0; #1;
      chk("wr_gnt", 32'(data_gnt), 32'h1);
      tick;
      data_req = 1'b0; data_we = 1'b0;
      chk("wr_rvalid", 32'(data_rvalid), 32'h1);
      chk("wr_err", 32'(data_err), 32'h1);
      chk("wr_rdata", data_rdata, 32'h0);
      instr_req = 1'b1; instr_addr = 32'h2; #1;
      chk("mis_gnt", 32'(instr_gnt), 32'h1);
      tick;
      instr_req = 1'b0;
      chk("mis_err", {30'h0, instr_rvalid, instr_err}, 32'h3);
      chk("mis_rdata", instr_rdata, 32'h0);
      chk("err_cleared", 32'(data_err), 32'h0);
      data_req = 1'b1; data_addr = 32'h5F0;
      tick;
      data_addr = 32'h4000;
      chk("oor_err", {30'h0, data_rvalid, data_err}, 32'h3);
      chk("oor_rdata", data_rdata, 32'h0);
      #1;
      chk("win_gnt", 32'(data_gnt), 32'h1);
      tick;
      data_addr = 32'h5EC;
      chk("win_err", {30'h0, data_rvalid, data_err}, 32'h3);
      chk("win_rdata", data_rdata, 32'h0);
      tick;
      data_req = 1'b0;
      chk("last_word_err", {30'h0, data_rvalid, data_err}, 32'h2);
      chk("last_word_rdata", data_rdata, 32'hB007_017B);
      tick;
      chk("last_word_after", {30'h0, data_rvalid, data_err}, 32'h0);

      // Contention where the winner is erroneous: priority is unaffected.
      instr_req = 1'b1; instr_addr = 32'h4000; data_req = 1'b1; data_addr = 32'h4; #1;
      chk("errpri_gnt1", {30'h0, instr_gnt, data_gnt}, 32'h2);
      tick;
      instr_req = 1'b0;
      chk("errpri_instr_err", {30'h0, instr_rvalid, instr_err}, 32'h3);
      #1;
      chk("errpri_gnt2", {30'h0, instr_gnt, data_gnt}, 32'h1);
      tick;
      data_req = 1'b0;
      chk("errpri_data_rdata", data_rdata, 32'hB007_0001);
      chk("errpri_data_err", {30'h0, data_rvalid, data_err}, 32'h2);

      // Back-to-back fetches.
      instr_req = 1'b1; instr_addr = 32'h0;
      tick;
      instr_addr = 32'h4;
      chk("b2b0", instr_rvalid ? instr_rdata : 32'hFFFF_FFFF, 32'hB007_0000);
      tick;
      instr_addr = 32'h8;
      chk("b2b1", instr_rvalid ? instr_rdata : 32'hFFFF_FFFF, 32'hB007_0001);
      tick;
      instr_req = 1'b0;
      chk("b2b2", instr_rvalid ? instr_rdata : 32'hFFFF_FFFF, 32'hB007_0002);
      tick;
      chk("b2b_end", 32'(instr_rvalid), 32'h0);

      // Reset in the cycle after a grant discards the response.
      instr_req = 1'b1; instr_addr = 32'hC; #1;
      chk("rmid_gnt", 32'(instr_gnt), 32'h1);
      tick;
      instr_req = 1'b0; rst = 1'b1; #1;
      chk("rmid_no_rvalid", 32'(instr_rvalid), 32'h0);
      tick;
      rst = 1'b0; #1;
      chk("rmid_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
      chk("rmid_instr_rdata", instr_rdata, 32'h0);
      chk("rmid_data_rdata", data_rdata, 32'h0);
      chk("rmid_mem_addr", mem_addr, 32'h0);
      instr_req = 1'b1; instr_addr = 32'h0; data_req = 1'b1; data_addr = 32'h0; #1;
      chk("rmid_first_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
      tick;
      instr_req = 1'b0;
      chk("rmid_instr_resp", 32'(instr_rvalid), 32'h1);
      #1;
      chk("rmid_data_gnt", 32'(data_gnt), 32'h1);
      tick;
      data_req = 1'b0;
      chk("rmid_data_resp", 32'(data_rvalid), 32'h1);

      // Lock pulse coinciding with a data read leaves that read intact.
      data_req = 1'b1; data_addr = 32'h15C; lock = 1'b1; #1;
      chk("lock_gnt", 32'(data_gnt), 32'h1);
      tick;
      lock = 1'b0;
      chk("lock_same_err", {30'h0, data_rvalid, data_err}, 32'h2);
      chk("lock_same_rdata", data_rdata, 32'hB007_0057);
      tick;
      data_req = 1'b0;
`ifdef BOOT_MEM_LOCK_EN
      chk("locked_err", {30'h0, data_rvalid, data_err}, 32'h3);
      chk("locked_rdata", data_rdata, 32'h0);
`else
      chk("unlocked_err", {30'h0, data_rvalid, data_err}, 32'h2);
      chk("unlocked_rdata", data_rdata, 32'hB007_0057);
`endif
      instr_req = 1'b1; instr_addr = 32'h15C;
      tick;
      instr_req = 1'b0;
      chk("lock_fetch_err", {30'h0, instr_rvalid, instr_err}, 32'h2);
      chk("lock_fetch_rdata", instr_rdata, 32'hB007_0057);
`ifdef BOOT_MEM_LOCK_EN
      rst = 1'b1;
      tick;
      rst = 1'b0; data_req = 1'b1; data_addr = 32'h15C;
      tick;
      data_req = 1'b0;
      chk("unlock_err", {30'h0, data_rvalid, data_err}, 32'h2);
      chk("unlock_rdata", data_rdata, 32'hB007_0057);
`endif
      tick;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/boot_mem_arbiter.md
Name: boot_mem_arbiter

Overview:
- Shares the single combinational boot ROM port between the core instruction-fetch bus and the core data bus.
- Sits between the core's two req/gnt/rvalid bus interfaces and the boot ROM (addr in, rdata out).
- Provides round-robin arbitration, registered read data with a one-cycle response, and error responses for illegal accesses.

Parameters:
- ADDR_WIDTH, 14: byte-address bits decoded; the ROM word index is addr[ADDR_WIDTH-1:2].
- MEM_WORDS, 380: number of populated ROM words. A word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- instr_req  input  1  fetch request
- instr_addr  input  32  fetch byte address
- instr_gnt  output  1  fetch request accepted this cycle
- instr_rvalid  output  1  fetch response valid
- instr_rdata  output  32  fetch response data
- instr_err  output  1  fetch response error
- data_req  input  1  data request
- data_we  input  1  data write enable
- data_addr  input  32  data byte address
- data_gnt  output  1  data request accepted
- data_rvalid  output  1  data response valid
- data_rdata  output  32  data response data
- data_err  output  1  data response error
- mem_addr  output  32  address driven to boot ROM
- mem_rdata  input  32  boot ROM combinational read data
- lock  input  1  one-cycle pulse that locks data-port ROM reads (used only with the optional feature)

Behaviour:
- Reset (one clk edge with rst=1): all gnt, rvalid and err outputs are 0; rdata outputs are 32'h0; mem_addr is 32'h0; last_owner is DATA, so INSTR wins first. Any response in flight when rst rises is discarded and never delivered.
- Clock and reset: one clock only. Reset is synchronous, active-high; it is sampled on the rising edge of clk.
- Grant rules:
  - gnt is combinational and asserted in the same cycle as req, for at most one port per cycle.
  - A request is accepted when req=1 and gnt=1. After an unaccepted cycle the requester holds req and addr stable.
- Arbitration:
  - If only one port requests, that port is granted.
  - If both request, the port that is not last_owner is granted.
  - last_owner updates on every accepted request.
  - Neither port ever waits more than one cycle behind the other.
- mem_addr:
  - equals the granted port's address;
  - otherwise holds its previous value, so there is no needless toggling.
- Response timing:
  - Exactly one cycle after acceptance, the accepted port sees rvalid=1 for one cycle, with rdata/err registered from that acceptance cycle.
  - A port may issue a new request in the cycle its rvalid is high (back-to-back).
  - Throughput is one access per cycle in total.
- Error classification, evaluated at acceptance; an error response gives err=1 and rdata=0:
  - addr[1:0] != 0 (misaligned);
  - word index >= MEM_WORDS;
  - addr[31:ADDR_WIDTH] != 0 (outside the boot window);
  - data_we=1 (the ROM is write-protected). Writes are still granted, and the ROM is never affected.
  - Fetches cannot write, so instr_err covers only the first three cases.
- Non-error responses: err=0 and rdata=mem_rdata sampled in the acceptance cycle.
- Response registers: when a port has no rvalid, its rdata holds its last value and its err is 0.
- Internal state: the registers last_owner, the per-port resp_valid/resp_err/resp_data, and locked (feature only). There is no FSM beyond these.
- Simultaneous events:
  - If both ports request and one is erroneous, arbitration still follows round-robin; error status does not affect priority.
  - A lock pulse in the same cycle as a data read does not affect that read.

Optional Feature:
- Macro: BOOT_MEM_LOCK_EN.
- With the macro defined:
  - A sticky locked register is set by lock=1 and cleared only by rst.
  - While locked=1, every accepted data-port read returns err=1 and rdata=0.
  - Instruction fetches are unaffected.
- Without the macro: the lock input is ignored (left unconnected internally) and no locked register exists.

Test Plan:
- Single fetch: instr_req with addr 0x0 -> instr_gnt the same cycle; next cycle instr_rvalid=1, instr_rdata equals the ROM word at 0, err=0.
- Contention: both ports request continuously; data_addr=0x10C, instr_addr=0x0 -> grants alternate INSTR, DATA, INSTR, DATA; each rvalid comes one cycle after its own grant; data_rdata = 32'h00000093.
- Errors:
  - data_we=1 at 0x0 -> gnt, then data_err=1 with rdata=0;
  - instr_addr=0x2 -> instr_err=1;
  - data_addr=0x5F0 (word 380) -> err=1;
  - data_addr=0x4000 -> err=1.
- Back-to-back fetches at 0x0, 0x4, 0x8 in consecutive cycles -> three consecutive instr_rvalid pulses carrying the corresponding ROM words.
- Reset mid-operation: assert rst in the cycle after a grant -> no rvalid is delivered; all outputs are 0 the cycle after; the first request after reset from both ports is granted to INSTR.
- BOOT_MEM_LOCK_EN:
  - pulse lock, then data read at 0x15C (word 87) -> data_err=1, rdata=0;
  - instr fetch at 0x15C still returns the ROM data;
  - after rst, the data read succeeds.
